// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//
// Pipeline hazard unit built around a per-register latency scoreboard.
// Every architectural register r (1..NREG-1) has a small down-counter cnt[r]
// that holds the number of advancing cycles left before its pending result
// can be forwarded. A D-stage consumer whose source counter is above 1 is
// held in decode. Once the counter reaches 1, the result is close enough
// for the M/W forwarding paths to supply it. Register 0 is hardwired zero
// and is never tracked.
//
// The unit also keeps the classic stall/flush priority scheme:
//   - exceptions beat everything,
//   - mispredicts beat decode hazards,
//   - pipeline-wide stalls (cache/divider/multiplier) freeze all stages.
// It also drives the E-stage operand forwarding selects.
//
// Optional build macro: HAZARD_PERF_EN adds three free-running 32-bit
// performance counters as extra output ports.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_cache_stall, d_cache_stall  memory misses in progress
//   div_stallE, mult_stallE       long-latency E-stage units busy
//   flush_jump_conflictE          E-stage jump redirect
//   flush_pred_failedM            branch mispredict resolved in M
//   flush_exceptionM              exception taken in M
//   rsD, rtD, rsE, rtE            D/E-stage source registers
//   reg_write_enD, reg_writeD     D-stage destination
//   latD                          D-stage result latency (0 treated as 1)
//   reg_write_enM/W, reg_writeM/W M/W destinations for forwarding
//   stallF..stallW                per-stage hold
//   flushF..flushW                per-stage bubble
//   forward_aE, forward_bE        00 none, 01 from M, 10 from W
//   perf_* (HAZARD_PERF_EN only)  hazard / pipe-stall / flush counters
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int NREG  = 32,
   parameter int RA_W  = 5,
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cache_stall,
   input  logic             d_cache_stall,
   input  logic             div_stallE,
   input  logic             mult_stallE,
   input  logic             flush_jump_conflictE,
   input  logic             flush_pred_failedM,
   input  logic             flush_exceptionM,
   input  logic [RA_W-1:0]  rsD,
   input  logic [RA_W-1:0]  rtD,
   input  logic [RA_W-1:0]  rsE,
   input  logic [RA_W-1:0]  rtE,
   input  logic             reg_write_enD,
   input  logic [RA_W-1:0]  reg_writeD,
   input  logic [LAT_W-1:0] latD,
   input  logic             reg_write_enM,
   input  logic [RA_W-1:0]  reg_writeM,
   input  logic             reg_write_enW,
   input  logic [RA_W-1:0]  reg_writeW,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             stallW,
   output logic             flushF,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic [1:0]       forward_aE,
   output logic [1:0]       forward_bE
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]      perf_hazard_cycles,
   output logic [31:0]      perf_pipe_stall_cycles,
   output logic [31:0]      perf_flush_events
`endif
);

   // Saturating decrement used by both the scoreboard and the E-stage copy.
   function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] x);
      return (x == '0) ? '0 : x - LAT_W'(1);
   endfunction

   logic [LAT_W-1:0] cnt [NREG];

   // Bookkeeping for the producer currently sitting in E, so that a
   // mispredict that kills it can put its destination counter back to the
   // value the older producer would have had.
   logic             v_e;
   logic [RA_W-1:0]  reg_e;
   logic [LAT_W-1:0] prev_e;

   logic             pstall;
   logic             adv;
   logic             haz_d;
   logic             issue;
   logic             kill;
   logic [LAT_W-1:0] cnt_rs;
   logic [LAT_W-1:0] cnt_rt;
   logic [LAT_W-1:0] cnt_wr;
   logic [LAT_W-1:0] lat_eff;

   // Scoreboard read ports. Register 0 and out-of-range addresses read as 0.
   // While rst is high the scoreboard is treated as empty, so the outputs
   // are well defined even before the first reset edge.
   always_comb begin
      cnt_rs = '0;
      cnt_rt = '0;
      cnt_wr = '0;
      for (int r = 1; r < NREG; r++) begin
         if (!rst && rsD == RA_W'(r))       cnt_rs = cnt[r];
         if (!rst && rtD == RA_W'(r))       cnt_rt = cnt[r];
         if (!rst && reg_writeD == RA_W'(r)) cnt_wr = cnt[r];
      end
   end

   // Hazard detection and stall/flush priority network.
   always_comb begin
      pstall  = i_cache_stall | d_cache_stall | div_stallE | mult_stallE;
      adv     = ~pstall;
      haz_d   = ((rsD != '0) && (cnt_rs > LAT_W'(1))) ||
                ((rtD != '0) && (cnt_rt > LAT_W'(1)));

      stallF  = ~flush_exceptionM & (pstall | (haz_d & ~flush_pred_failedM));
      stallD  = ~flush_exceptionM & (haz_d | pstall);
      stallE  = ~flush_exceptionM & pstall;
      stallM  = ~flush_exceptionM & pstall;
      stallW  = pstall;

      flushF  = 1'b0;
      flushW  = 1'b0;
      flushD  = flush_exceptionM | (flush_pred_failedM & adv) |
                (flush_jump_conflictE & adv & ~haz_d);
      flushE  = flush_exceptionM | (flush_pred_failedM & adv) | (haz_d & adv);
      flushM  = flush_exceptionM;

      lat_eff = (latD == '0) ? LAT_W'(1) : latD;
      issue   = adv & ~stallD & ~flushE & reg_write_enD & (reg_writeD != '0);
      // A resolving mispredict squashes the instruction in E; a hazard bubble
      // does not, because that instruction still moves on to M.
      kill    = v_e & flush_pred_failedM & adv;
   end

   // E-stage operand forwarding: M is younger than W, so it wins.
   always_comb begin
      forward_aE = 2'b00;
      forward_bE = 2'b00;
      if (rsE != '0 && reg_write_enM && reg_writeM == rsE)      forward_aE = 2'b01;
      else if (rsE != '0 && reg_write_enW && reg_writeW == rsE) forward_aE = 2'b10;
      if (rtE != '0 && reg_write_enM && reg_writeM == rtE)      forward_bE = 2'b01;
      else if (rtE != '0 && reg_write_enW && reg_writeW == rtE) forward_bE = 2'b10;
   end

   // Scoreboard update. An exception drains the pipe, so every pending
   // result is forgotten. Otherwise a kill restore or a fresh issue replaces
   // the normal aging step for its own entry.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NREG; r++) begin
         if (rst || flush_exceptionM || r == 0)
            cnt[r] <= '0;
         else if (kill && reg_e == RA_W'(r))
            cnt[r] <= prev_e;
         else if (issue && reg_writeD == RA_W'(r))
            cnt[r] <= lat_eff;
         else if (adv)
            cnt[r] <= sat_dec(cnt[r]);
      end
   end

   // Tracking of the producer now in E. prev_e is the aged value of the
   // counter it overwrote, which is what a kill must restore.
   always_ff @(posedge clk) begin
      if (rst || flush_exceptionM) begin
         v_e    <= 1'b0;
         reg_e  <= '0;
         prev_e <= '0;
      end else if (kill) begin
         v_e    <= 1'b0;
      end else if (issue) begin
         v_e    <= 1'b1;
         reg_e  <= reg_writeD;
         prev_e <= sat_dec(cnt_wr);
      end else if (adv) begin
         v_e    <= 1'b0;
         if (v_e) prev_e <= sat_dec(prev_e);
      end
   end

`ifdef HAZARD_PERF_EN
   // Free-running event counters that wrap naturally at 2^32. Exceptions do
   // not clear them.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_hazard_cycles     <= '0;
         perf_pipe_stall_cycles <= '0;
         perf_flush_events      <= '0;
      end else begin
         if (haz_d && adv)     perf_hazard_cycles     <= perf_hazard_cycles + 32'd1;
         if (pstall)           perf_pipe_stall_cycles <= perf_pipe_stall_cycles + 32'd1;
         if (flushD || flushE) perf_flush_events      <= perf_flush_events + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Self-checking bench for hazard_scoreboard. A behavioural model tracks, for
// each register, the advance-cycle time at which its result is ready. It
// predicts every output each cycle. Directed scenarios cover ALU, load-use,
// long-op, mispredict, exception and forwarding cases, with explicit checks
// of the expected stall counts. A randomized phase then follows.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;

   typedef struct packed {
      logic       rst;
      logic       ic;
      logic       dc;
      logic       dv;
      logic       ml;
      logic       fjc;
      logic       fpm;
      logic       fex;
      logic [4:0] rsD;
      logic [4:0] rtD;
      logic [4:0] rsE;
      logic [4:0] rtE;
      logic       wenD;
      logic [4:0] wrD;
      logic [2:0] lat;
      logic       wenM;
      logic [4:0] wrM;
      logic       wenW;
      logic [4:0] wrW;
   } stim_t;

   logic       clk;
   logic       rst;
   logic       i_cache_stall, d_cache_stall, div_stallE, mult_stallE;
   logic       flush_jump_conflictE, flush_pred_failedM, flush_exceptionM;
   logic [4:0] rsD, rtD, rsE, rtE, reg_writeD, reg_writeM, reg_writeW;
   logic       reg_write_enD, reg_write_enM, reg_write_enW;
   logic [2:0] latD;
   logic       stallF, stallD, stallE, stallM, stallW;
   logic       flushF, flushD, flushE, flushM, flushW;
   logic [1:0] forward_aE, forward_bE;

   hazard_scoreboard #(.NREG(32), .RA_W(5), .LAT_W(3)) dut (
      .clk(clk), .rst(rst),
      .i_cache_stall(i_cache_stall), .d_cache_stall(d_cache_stall),
      .div_stallE(div_stallE), .mult_stallE(mult_stallE),
      .flush_jump_conflictE(flush_jump_conflictE),
      .flush_pred_failedM(flush_pred_failedM),
      .flush_exceptionM(flush_exceptionM),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .reg_write_enD(reg_write_enD), .reg_writeD(reg_writeD), .latD(latD),
      .reg_write_enM(reg_write_enM), .reg_writeM(reg_writeM),
      .reg_write_enW(reg_write_enW), .reg_writeW(reg_writeW),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .stallW(stallW),
      .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM),
      .flushW(flushW),
      .forward_aE(forward_aE), .forward_bE(forward_bE)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute bound on the run in case something stalls the sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   int testCount = 0;
   int failCount = 0;

   // Model state: ready[r] is the advance-count at which r is fully ready.
   stim_t cur;
   int    advClk;
   int    ready [32];
   bit    pendValid;
   int    pendReg;
   int    pendRem;

   // Expected values for the cycle under test.
   bit eStallF, eStallD, eStallE, eStallM, eStallW;
   bit eFlushD, eFlushE, eFlushM, eAdv, eIssue;
   logic [1:0] eFa, eFb;

   function automatic int remaining(int r);
      int d;
      if (r == 0 || cur.rst) return 0;
      d = ready[r] - advClk;
      return (d > 0) ? d : 0;
   endfunction

   function automatic logic [1:0] fwdSel(logic [4:0] src);
      if (src == 0) return 2'b00;
      if (cur.wenM && cur.wrM == src) return 2'b01;
      if (cur.wenW && cur.wrW == src) return 2'b10;
      return 2'b00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      cur                  = s;
      rst                  = s.rst;
      i_cache_stall        = s.ic;
      d_cache_stall        = s.dc;
      div_stallE           = s.dv;
      mult_stallE          = s.ml;
      flush_jump_conflictE = s.fjc;
      flush_pred_failedM   = s.fpm;
      flush_exceptionM     = s.fex;
      rsD                  = s.rsD;
      rtD                  = s.rtD;
      rsE                  = s.rsE;
      rtE                  = s.rtE;
      reg_write_enD        = s.wenD;
      reg_writeD           = s.wrD;
      latD                 = s.lat;
      reg_write_enM        = s.wenM;
      reg_writeM           = s.wrM;
      reg_write_enW        = s.wenW;
      reg_writeW           = s.wrW;
   endtask

   task automatic predict();
      bit pst, haz;
      pst     = cur.ic | cur.dc | cur.dv | cur.ml;
      eAdv    = !pst;
      haz     = (remaining(int'(cur.rsD)) > 1) || (remaining(int'(cur.rtD)) > 1);
      eStallF = !cur.fex && (pst || (haz && !cur.fpm));
      eStallD = !cur.fex && (haz || pst);
      eStallE = !cur.fex && pst;
      eStallM = eStallE;
      eStallW = pst;
      eFlushD = cur.fex || (cur.fpm && eAdv) || (cur.fjc && eAdv && !haz);
      eFlushE = cur.fex || (cur.fpm && eAdv) || (haz && eAdv);
      eFlushM = cur.fex;
      eIssue  = eAdv && !eStallD && !eFlushE && cur.wenD && cur.wrD != 0;
      eFa     = fwdSel(cur.rsE);
      eFb     = fwdSel(cur.rtE);
   endtask

   task automatic checkOutput();
      predict();
      chk("stallF", stallF, eStallF);
      chk("stallD", stallD, eStallD);
      chk("stallE", stallE, eStallE);
      chk("stallM", stallM, eStallM);
      chk("stallW", stallW, eStallW);
      chk("flushF", flushF, 0);
      chk("flushD", flushD, eFlushD);
      chk("flushE", flushE, eFlushE);
      chk("flushM", flushM, eFlushM);
      chk("flushW", flushW, 0);
      chk("forward_aE", forward_aE, eFa);
      chk("forward_bE", forward_bE, eFb);
   endtask

   // Model state change across one rising edge, using this cycle's inputs.
   task automatic modelUpdate();
      int lat;
      int rem;
      if (eAdv) advClk++;
      if (cur.rst || cur.fex) begin
         for (int r = 0; r < 32; r++) ready[r] = advClk;
         pendValid = 0;
      end else if (pendValid && cur.fpm && eAdv) begin
         ready[pendReg] = advClk + pendRem;
         pendValid      = 0;
      end else if (eIssue) begin
         rem            = ready[cur.wrD] - advClk;
         pendRem        = (rem > 0) ? rem : 0;
         pendReg        = int'(cur.wrD);
         pendValid      = 1;
         lat            = (cur.lat == 0) ? 1 : int'(cur.lat);
         ready[cur.wrD] = advClk + lat;
      end else if (eAdv) begin
         pendValid = 0;
      end
   endtask

   task automatic cycle(input stim_t s);
      applyStimulus(s);
      #2;
      checkOutput();
   endtask

   task automatic tick();
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   stim_t s;
   int    n;
   bit    done;

   initial begin
      advClk    = 0;
      pendValid = 0;
      pendReg   = 0;
      pendRem   = 0;
      for (int r = 0; r < 32; r++) ready[r] = 0;

      // Reset.
      s = '0; s.rst = 1'b1;
      cycle(s); chk("reset_stallD", stallD, 0); chk("reset_fa", forward_aE, 0); tick();
      cycle(s); tick();

      // ALU producer: consumer next cycle does not stall, then forwards from M.
      s = '0; s.wenD = 1; s.wrD = 5; s.lat = 1;
      cycle(s); tick();
      s = '0; s.rsD = 5;
      cycle(s); chk("alu_nostall", stallD, 0); tick();
      s = '0; s.rsE = 5; s.wenM = 1; s.wrM = 5;
      cycle(s); chk("alu_fwdM", forward_aE, 2'b01); tick();

      // Load-use: exactly one bubble, then forward from W.
      s = '0; s.wenD = 1; s.wrD = 5; s.lat = 2;
      cycle(s); tick();
      s = '0; s.rsD = 5;
      cycle(s); chk("ld_stallD", stallD, 1); chk("ld_flushE", flushE, 1); tick();
      cycle(s); chk("ld_release", stallD, 0); tick();
      s = '0; s.rsE = 5; s.wenW = 1; s.wrW = 5;
      cycle(s); chk("ld_fwdW", forward_aE, 2'b10); tick();

      // Long op: four stall cycles.
      s = '0; s.wenD = 1; s.wrD = 7; s.lat = 5;
      cycle(s); tick();
      n = 0;
      for (int k = 0; k < 20; k++) begin
         s = '0; s.rtD = 7;
         cycle(s);
         if (stallD) n++;
         done = !stallD;
         tick();
         if (done) break;
      end
      chk("long_stalls", n, 4);

      // Long op with a 3-cycle data miss in the middle: seven stall cycles.
      s = '0; s.wenD = 1; s.wrD = 7; s.lat = 5;
      cycle(s); tick();
      n = 0;
      for (int k = 0; k < 20; k++) begin
         s = '0; s.rtD = 7; s.dc = (k >= 1 && k <= 3);
         cycle(s);
         if (stallD) n++;
         done = !stallD;
         tick();
         if (done) break;
      end
      chk("long_miss_stalls", n, 7);

      // Mispredict kills the long producer of r9; later reader does not stall.
      s = '0; s.wenD = 1; s.wrD = 9; s.lat = 4;
      cycle(s); tick();
      s = '0; s.fpm = 1;
      cycle(s); chk("mp_flushD", flushD, 1); chk("mp_flushE", flushE, 1); tick();
      s = '0; s.rsD = 9;
      cycle(s); chk("mp_nostall", stallD, 0); tick();

      // Exception during a data miss with r3 pending.
      s = '0; s.wenD = 1; s.wrD = 3; s.lat = 5;
      cycle(s); tick();
      s = '0; s.fex = 1; s.dc = 1; s.rsD = 3;
      cycle(s);
      chk("exc_stallD", stallD, 0); chk("exc_flushD", flushD, 1);
      chk("exc_flushE", flushE, 1); chk("exc_flushM", flushM, 1);
      chk("exc_stallW", stallW, 1);
      tick();
      s = '0; s.rsD = 3;
      cycle(s); chk("exc_cleared", stallD, 0); tick();

      // Forwarding priority and register 0.
      s = '0; s.rsE = 4; s.wenM = 1; s.wrM = 4; s.wenW = 1; s.wrW = 4;
      cycle(s); chk("fwd_both", forward_aE, 2'b01); tick();
      s = '0; s.rsE = 0; s.wenM = 1; s.wrM = 0; s.rtE = 6; s.wenW = 1; s.wrW = 6;
      cycle(s); chk("fwd_zero", forward_aE, 2'b00); chk("fwd_bW", forward_bE, 2'b10); tick();

      // Randomized traffic over a small register window to provoke hazards.
      for (int k = 0; k < 600; k++) begin
         s      = '0;
         s.rst  = ($urandom_range(0, 99) == 0);
         s.ic   = ($urandom_range(0, 9) == 0);
         s.dc   = ($urandom_range(0, 9) == 0);
         s.dv   = ($urandom_range(0, 19) == 0);
         s.ml   = ($urandom_range(0, 19) == 0);
         s.fjc  = ($urandom_range(0, 9) == 0);
         s.fpm  = ($urandom_range(0, 11) == 0);
         s.fex  = ($urandom_range(0, 29) == 0);
         s.rsD  = 5'($urandom_range(0, 7));
         s.rtD  = 5'($urandom_range(0, 7));
         s.rsE  = 5'($urandom_range(0, 7));
         s.rtE  = 5'($urandom_range(0, 7));
         s.wenD = ($urandom_range(0, 3) != 0);
         s.wrD  = 5'($urandom_range(0, 7));
         s.lat  = 3'($urandom_range(0, 7));
         s.wenM = $urandom_range(0, 1) != 0;
         s.wrM  = 5'($urandom_range(0, 7));
         s.wenW = $urandom_range(0, 1) != 0;
         s.wrW  = 5'($urandom_range(0, 7));
         cycle(s);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the 5-stage pipeline hazard unit. It keeps the M/W forwarding selection and the stall/flush priority scheme. The fixed load-use check is replaced by a per-register latency scoreboard, so producers with any result latency (load, multi-cycle cache hit, long-latency ALU ops) generate exactly the required number of decode stalls. It sits beside the datapath and drives every stage's stall/flush and the E-stage forwarding muxes.

Parameters:
NREG, 32, number of architectural registers; register 0 is hardwired zero and is never tracked.
RA_W, 5, register address width; must satisfy 2^RA_W >= NREG.
LAT_W, 3, latency counter width; maximum producer latency is 2^LAT_W-1.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
i_cache_stall  in  1  fetch miss in progress
d_cache_stall  in  1  data miss in progress
div_stallE  in  1  divider busy
mult_stallE  in  1  multiplier busy
flush_jump_conflictE  in  1  E-stage jump redirect
flush_pred_failedM  in  1  branch mispredict resolved in M
flush_exceptionM  in  1  exception taken in M
rsD, rtD  in  RA_W  D-stage source registers
rsE, rtE  in  RA_W  E-stage source registers
reg_write_enD  in  1  D-stage instruction writes a register
reg_writeD  in  RA_W  D-stage destination register
latD  in  LAT_W  D-stage result latency: 1 = ALU, 2 = load, >2 = long op; 0 is treated as 1
reg_write_enM, reg_write_enW  in  1  M/W write enables
reg_writeM, reg_writeW  in  RA_W  M/W destination registers
stallF, stallD, stallE, stallM, stallW  out  1  stage hold
flushF, flushD, flushE, flushM, flushW  out  1  stage bubble
forward_aE, forward_bE  out  2  00 none, 01 from M, 10 from W

Behaviour:
- Scoreboard: cnt[r] (LAT_W bits) for r = 1..NREG-1. Reset clears all to 0.
- Definitions: pstall = i_cache_stall | d_cache_stall | div_stallE | mult_stallE; adv = ~pstall.
- hazD = (rsD != 0 & cnt[rsD] > 1) | (rtD != 0 & cnt[rtD] > 1).
- issue = adv & ~stallD & ~flushE & reg_write_enD & reg_writeD != 0.
- Counter update each cycle:
  - if adv, every nonzero cnt decrements by 1, saturating at 0;
  - if issue, cnt[reg_writeD] = max(latD,1), taking priority over the decrement for that entry.
- E tracking registers: vE, regE, prevE.
  - On issue: vE = 1, regE = reg_writeD, prevE = old cnt[reg_writeD] saturating-decremented.
  - On adv without issue: vE = 0.
  - While vE = 1, prevE decrements on adv.
- Kill restore: when flushE or flushD-with-kill-of-E is asserted (flush_exceptionM or flush_pred_failedM) while vE = 1, cnt[regE] = prevE and vE = 0.
- flush_exceptionM additionally clears all cnt to 0 on the next edge.
- Outputs:
  - stallF = ~flush_exceptionM & (pstall | (hazD & ~flush_pred_failedM))
  - stallD = ~flush_exceptionM & (hazD | pstall)
  - stallE = stallM = ~flush_exceptionM & pstall
  - stallW = pstall
  - flushF = flushW = 0
  - flushD = flush_exceptionM | (flush_pred_failedM & adv) | (flush_jump_conflictE & adv & ~hazD)
  - flushE = flush_exceptionM | (flush_pred_failedM & adv) | (hazD & adv)
  - flushM = flush_exceptionM
- Forwarding: M has priority over W; a source of 0 never forwards. Same-cycle match in both M and W gives 01.
- Registered outputs: none; all outputs are combinational from inputs and scoreboard state. During rst = 1, outputs follow the combinational rules with cnt = 0.

Optional Feature:
HAZARD_PERF_EN:
- When defined, adds outputs perf_hazard_cycles (32), perf_pipe_stall_cycles (32) and perf_flush_events (32).
  - perf_hazard_cycles counts cycles with hazD & adv.
  - perf_pipe_stall_cycles counts cycles with pstall.
  - perf_flush_events counts cycles with flushD | flushE.
- All three wrap at 2^32, are cleared by rst, and hold during flush_exceptionM except for their own increment.
- When not defined, these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
1. ALU producer: issue r5 with latD=1, then consumer rsD=5 next cycle -> hazD=0, no stall, forward_aE=01 in E.
2. Load-use: issue r5 with latD=2, consumer rsD=5 -> exactly 1 cycle stallD=1/flushE=1, then proceed with forward_aE=10.
3. Long op: issue r7 with latD=5, consumer rtD=7 -> 4 stall cycles. Asserting d_cache_stall for 3 cycles in the middle extends this to 7 total without cnt change during pstall.
4. Mispredict: issue r9 with latD=4 (prior cnt[9]=0), then flush_pred_failedM next cycle -> cnt[9]=0, and a later rsD=9 does not stall.
5. Exception with pending cnt[3]=5 and d_cache_stall=1 -> stallD=0, flushD/E/M=1, all cnt=0 next cycle.
6. Same-cycle M and W both match rsE=4 -> forward_aE=01; rsE=0 with reg_writeM=0 -> 00.
